// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared state encoding, forwarding selects and the forwarding priority rule
// for the RV32I pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_WAIT = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // The younger producer in M shadows W; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       regwrite_m,
        input logic       regwrite_w
    );
        logic [1:0] sel;
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard inputs from the datapath and
// the stall/flush/forward controls going back to it.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic             load_e, pcsrc_e, regwrite_m, regwrite_w;
    logic             dmem_req_m, dmem_ready, mdu_start_e, mdu_done, perf_clr;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_m, flush_w;
    logic [1:0]       fwd_a_e, fwd_b_e;
    logic             busy, err_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output load_e, pcsrc_e, regwrite_m, regwrite_w,
        output dmem_req_m, dmem_ready, mdu_start_e, mdu_done, perf_clr,
        input  stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_m, flush_w,
        input  fwd_a_e, fwd_b_e, busy, err_timeout, stall_cycles
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input  load_e, pcsrc_e, regwrite_m, regwrite_w,
        input  dmem_req_m, dmem_ready, mdu_start_e, mdu_done, perf_clr,
        output stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_m, flush_w,
        output fwd_a_e, fwd_b_e, busy, err_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Dual-operand ALU forwarding select for the instruction in E.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);
    assign fwd_a = fwd_sel(rs1_e, rd_m, rd_w, regwrite_m, regwrite_w);
    assign fwd_b = fwd_sel(rs2_e, rd_m, rd_w, regwrite_m, regwrite_w);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage RV32I pipeline,
// with memory / mul-div wait sequencing, watchdog and stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input logic             clk,
    input logic             rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int              WC_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    ctrl_state_e      state_r, state_nxt_s;
    logic [WC_W-1:0]  wait_cnt_r;
    logic             err_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             memwait_s, lu_s;
    logic             stall_f_s, stall_d_s, stall_e_s, stall_m_s;
    logic             flush_d_s, flush_e_s, flush_m_s, flush_w_s;
    logic [1:0]       fwd_a_s, fwd_b_s;

    fwd_unit u_fwd (
        .rs1_e      (bus.rs1_e),
        .rs2_e      (bus.rs2_e),
        .rd_m       (bus.rd_m),
        .rd_w       (bus.rd_w),
        .regwrite_m (bus.regwrite_m),
        .regwrite_w (bus.regwrite_w),
        .fwd_a      (fwd_a_s),
        .fwd_b      (fwd_b_s)
    );

    assign memwait_s = bus.dmem_req_m && !bus.dmem_ready;
    assign lu_s      = bus.load_e && (bus.rd_e != 5'd0) &&
                       ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

    // Stall/flush decode and next-state selection, memory wait first.
    always_comb begin
        state_nxt_s = state_r;
        stall_f_s   = 1'b0;
        stall_d_s   = 1'b0;
        stall_e_s   = 1'b0;
        stall_m_s   = 1'b0;
        flush_d_s   = 1'b0;
        flush_e_s   = 1'b0;
        flush_m_s   = 1'b0;
        flush_w_s   = 1'b0;
        if (rst) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (memwait_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
            if (state_r == RUN) begin
                state_nxt_s = MEM_WAIT;
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            case (state_r)
                // The MEM_WAIT release cycle behaves like a normal RUN cycle.
                RUN, MEM_WAIT: begin
                    if (bus.mdu_start_e && !bus.mdu_done) begin
                        stall_f_s   = 1'b1;
                        stall_d_s   = 1'b1;
                        stall_e_s   = 1'b1;
                        flush_m_s   = 1'b1;
                        state_nxt_s = MDU_WAIT;
                    end else if (bus.pcsrc_e) begin
                        flush_d_s   = 1'b1;
                        flush_e_s   = 1'b1;
                        state_nxt_s = RUN;
                    end else if (lu_s) begin
                        stall_f_s   = 1'b1;
                        stall_d_s   = 1'b1;
                        flush_e_s   = 1'b1;
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                MDU_WAIT: begin
                    if (bus.mdu_done) begin
                        state_nxt_s = RUN;
                    end else begin
                        stall_f_s   = 1'b1;
                        stall_d_s   = 1'b1;
                        stall_e_s   = 1'b1;
                        flush_m_s   = 1'b1;
                        state_nxt_s = MDU_WAIT;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                end
            endcase
        end
    end

    // Forwarding is held at the register file while in reset.
    always_comb begin
        if (rst) begin
            bus.fwd_a_e = FWD_RF;
            bus.fwd_b_e = FWD_RF;
        end else begin
            bus.fwd_a_e = fwd_a_s;
            bus.fwd_b_e = fwd_b_s;
        end
    end

    // FSM state, saturating wait counter and sticky watchdog flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RUN;
            wait_cnt_r <= {WC_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == RUN) begin
                wait_cnt_r <= {WC_W{1'b0}};
            end else if (wait_cnt_r != WC_LAST) begin
                wait_cnt_r <= wait_cnt_r + WC_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if ((state_r != RUN) && (wait_cnt_r == WC_LAST)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Saturating count of fetch-stall cycles; perf_clr wins over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (bus.perf_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_f_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.stall_f      = stall_f_s;
    assign bus.stall_d      = stall_d_s;
    assign bus.stall_e      = stall_e_s;
    assign bus.stall_m      = stall_m_s;
    assign bus.flush_d      = flush_d_s;
    assign bus.flush_e      = flush_e_s;
    assign bus.flush_m      = flush_m_s;
    assign bus.flush_w      = flush_w_s;
    assign bus.busy         = (state_r != RUN);
    assign bus.err_timeout  = err_r;
    assign bus.stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=8, 4-bit counter).
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if #(.CNT_W(4)) pif ();

    pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    always #5 clk = ~clk;

    logic [3:0] stall_v, flush_v;
    assign stall_v = {pif.stall_f, pif.stall_d, pif.stall_e, pif.stall_m};
    assign flush_v = {pif.flush_d, pif.flush_e, pif.flush_m, pif.flush_w};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pif.rs1_d = 5'd0; pif.rs2_d = 5'd0; pif.rs1_e = 5'd0; pif.rs2_e = 5'd0;
        pif.rd_e = 5'd0; pif.rd_m = 5'd0; pif.rd_w = 5'd0;
        pif.load_e = 1'b0; pif.pcsrc_e = 1'b0;
        pif.regwrite_m = 1'b0; pif.regwrite_w = 1'b0;
        pif.dmem_req_m = 1'b0; pif.dmem_ready = 1'b0;
        pif.mdu_start_e = 1'b0; pif.mdu_done = 1'b0; pif.perf_clr = 1'b0;
    endtask

    initial begin
        // Reset values, with a forwarding hit present to show it is masked.
        idle();
        pif.regwrite_m = 1'b1; pif.rd_m = 5'd3; pif.rs1_e = 5'd3;
        #2;
        chk("rst_stall", 32'(stall_v), 32'h0);
        chk("rst_flush", 32'(flush_v), 32'hC);
        chk("rst_fwd_a", 32'(pif.fwd_a_e), 32'h0);
        chk("rst_busy", 32'(pif.busy), 32'h0);
        chk("rst_err", 32'(pif.err_timeout), 32'h0);
        chk("rst_cnt", 32'(pif.stall_cycles), 32'h0);

        // Forwarding: M wins over W, rd_m = 0 falls back to W.
        @(negedge clk); rst = 1'b0;
        pif.regwrite_w = 1'b1; pif.rd_w = 5'd3; pif.rs2_e = 5'd4; #1;
        chk("fwd_a_m", 32'(pif.fwd_a_e), 32'h2);
        chk("fwd_b_none", 32'(pif.fwd_b_e), 32'h0);
        chk("fwd_flush", 32'(flush_v), 32'h0);
        @(negedge clk); pif.rd_m = 5'd0; pif.rs2_e = 5'd3; #1;
        chk("fwd_a_w", 32'(pif.fwd_a_e), 32'h1);
        chk("fwd_b_w", 32'(pif.fwd_b_e), 32'h1);
        @(negedge clk); pif.rd_m = 5'd3; pif.regwrite_m = 1'b0; pif.rd_w = 5'd0; #1;
        chk("fwd_none", 32'(pif.fwd_a_e), 32'h0);

        // Load-use: one cycle of stall_f/d + flush_e.
        @(negedge clk); idle(); pif.load_e = 1'b1; pif.rd_e = 5'd5; pif.rs1_d = 5'd5; #1;
        chk("lu_stall", 32'(stall_v), 32'hC);
        chk("lu_flush", 32'(flush_v), 32'h4);
        @(negedge clk); pif.load_e = 1'b0; #1;
        chk("lu_after_stall", 32'(stall_v), 32'h0);
        chk("lu_after_flush", 32'(flush_v), 32'h0);
        chk("lu_cnt", 32'(pif.stall_cycles), 32'h1);
        @(negedge clk); pif.load_e = 1'b1; pif.rd_e = 5'd0; pif.rs1_d = 5'd0; #1;
        chk("lu_x0", 32'(stall_v), 32'h0);

        // Redirect overrides load-use.
        @(negedge clk); pif.rd_e = 5'd5; pif.rs1_d = 5'd5; pif.pcsrc_e = 1'b1; #1;
        chk("redir_stall", 32'(stall_v), 32'h0);
        chk("redir_flush", 32'(flush_v), 32'hC);

        // Memory wait with a redirect pending: three stalled cycles.
        @(negedge clk); idle(); pif.pcsrc_e = 1'b1; pif.dmem_req_m = 1'b1; #1;
        chk("mw1_stall", 32'(stall_v), 32'hF);
        chk("mw1_flush", 32'(flush_v), 32'h1);
        chk("mw1_busy", 32'(pif.busy), 32'h0);
        @(negedge clk); #1;
        chk("mw2_stall", 32'(stall_v), 32'hF);
        chk("mw2_flush", 32'(flush_v), 32'h1);
        chk("mw2_busy", 32'(pif.busy), 32'h1);
        @(negedge clk); #1;
        chk("mw3_stall", 32'(stall_v), 32'hF);
        chk("mw3_busy", 32'(pif.busy), 32'h1);
        @(negedge clk); pif.dmem_ready = 1'b1; pif.pcsrc_e = 1'b0; #1;
        chk("mw4_stall", 32'(stall_v), 32'h0);
        chk("mw4_flush", 32'(flush_v), 32'h0);
        @(negedge clk); idle(); #1;
        chk("mw_run", 32'(pif.busy), 32'h0);
        chk("mw_cnt", 32'(pif.stall_cycles), 32'h4);

        // Mul/div: 4 stalled cycles, release on done.
        @(negedge clk); pif.perf_clr = 1'b1; #1;
        @(negedge clk); pif.perf_clr = 1'b0; pif.mdu_start_e = 1'b1; #1;
        chk("md1_cnt", 32'(pif.stall_cycles), 32'h0);
        chk("md1_stall", 32'(stall_v), 32'hE);
        chk("md1_flush", 32'(flush_v), 32'h2);
        @(negedge clk); #1;
        chk("md2_busy", 32'(pif.busy), 32'h1);
        chk("md2_stall", 32'(stall_v), 32'hE);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("md4_flush", 32'(flush_v), 32'h2);
        @(negedge clk); pif.mdu_done = 1'b1; #1;
        chk("md5_stall", 32'(stall_v), 32'h0);
        chk("md5_flush", 32'(flush_v), 32'h0);
        @(negedge clk); idle(); #1;
        chk("md_run", 32'(pif.busy), 32'h0);
        chk("md_cnt", 32'(pif.stall_cycles), 32'h4);
        @(negedge clk); pif.mdu_start_e = 1'b1; pif.mdu_done = 1'b1; #1;
        chk("md_same_stall", 32'(stall_v), 32'h0);
        @(negedge clk); idle(); #1;
        chk("md_same_busy", 32'(pif.busy), 32'h0);

        // perf_clr beats a concurrent stall.
        @(negedge clk); pif.load_e = 1'b1; pif.rd_e = 5'd5; pif.rs1_d = 5'd5; pif.perf_clr = 1'b1; #1;
        chk("pc_stall", 32'(stall_v), 32'hC);
        @(negedge clk); idle(); #1;
        chk("pc_cnt", 32'(pif.stall_cycles), 32'h0);

        // Watchdog: mdu_done never arrives.
        @(negedge clk); pif.mdu_start_e = 1'b1; #1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk); #1;
            if (i == 7)  chk("wd_err_early", 32'(pif.err_timeout), 32'h0);
            if (i == 9)  chk("wd_err_set", 32'(pif.err_timeout), 32'h1);
            if (i == 14) chk("wd_cnt14", 32'(pif.stall_cycles), 32'hE);
            if (i == 16) chk("wd_cnt_sat", 32'(pif.stall_cycles), 32'hF);
        end
        chk("wd_err_sticky", 32'(pif.err_timeout), 32'h1);
        chk("wd_busy", 32'(pif.busy), 32'h1);
        chk("wd_cnt20", 32'(pif.stall_cycles), 32'hF);

        // Asynchronous reset mid-wait, before any clock edge.
        #2; rst = 1'b1; #1;
        chk("arst_busy", 32'(pif.busy), 32'h0);
        chk("arst_err", 32'(pif.err_timeout), 32'h0);
        chk("arst_cnt", 32'(pif.stall_cycles), 32'h0);
        chk("arst_stall", 32'(stall_v), 32'h0);
        chk("arst_flush", 32'(flush_v), 32'hC);
        @(negedge clk); rst = 1'b0; idle(); #1;
        chk("post_busy", 32'(pif.busy), 32'h0);
        chk("post_stall", 32'(stall_v), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage RV32I pipeline.
- Drives the enable and clear inputs of the F/D, D/E, E/M and M/W pipeline registers (en = ~stall_x, clr = flush_x). The register clear input has priority over its enable.
- Sequences multi-cycle waits for data memory and the mul/div unit.
- Keeps a watchdog and a stall-cycle performance counter.

Parameters:
- TIMEOUT, 1024, wait cycles in MEM_WAIT/MDU_WAIT before err_timeout sets.
- CNT_W, 32, width of the stall_cycles counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- rs1_d, rs2_d  in  5  source registers of the instruction in D.
- rs1_e, rs2_e, rd_e  in  5  sources and destination of the instruction in E.
- load_e  in  1  instruction in E is a load.
- pcsrc_e  in  1  branch/jump taken in E (redirect).
- rd_m, rd_w  in  5  destinations of the instructions in M and W.
- regwrite_m, regwrite_w  in  1  register writes in M and W.
- dmem_req_m  in  1  memory access in M.
- dmem_ready  in  1  memory access completes this cycle.
- mdu_start_e  in  1  mul/div instruction in E.
- mdu_done  in  1  mul/div result valid this cycle.
- perf_clr  in  1  synchronous clear of stall_cycles.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the PC and the F/D, D/E, E/M registers.
- flush_d, flush_e, flush_m, flush_w  out  1  bubble the D, E, M, W registers.
- fwd_a_e, fwd_b_e  out  2  ALU operand select.
- busy  out  1  state is not RUN.
- err_timeout  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_f = 1.

Behaviour:
- **Reset values.** Async rst sets state = RUN, wait_cnt = 0, err_timeout = 0, stall_cycles = 0. While rst is high, all stall outputs = 0, flush_d = flush_e = 1, flush_m = flush_w = 0, fwd = 00.
- **FSM states.** RUN, MEM_WAIT, MDU_WAIT. Stall/flush outputs are combinational from state and inputs.
- **Forwarding** (decided independently of the stall logic). fwd_a_e = 10 if regwrite_m && rd_m != 0 && rd_m == rs1_e. Otherwise 01 if the same test holds for W. Otherwise 00. fwd_b_e uses the same rule with rs2_e.
- **Memory stall, highest priority.**
  - memwait = dmem_req_m && !dmem_ready. This applies in any state.
  - While memwait: stall_f/d/e/m = 1, flush_w = 1, and flush_d = flush_e = flush_m = 0 (no redirect or load-use action).
  - In RUN, memwait moves to MEM_WAIT. In MEM_WAIT, !memwait moves to RUN; in that cycle stalls drop and the load data is captured.
- **Mul/div.**
  - In RUN with !memwait && mdu_start_e && !mdu_done: stall_f/d/e = 1, flush_m = 1, next state MDU_WAIT.
  - mdu_start_e && mdu_done in the same RUN cycle: no stall.
  - In MDU_WAIT, mdu_start_e is ignored. The stalls hold until the mdu_done cycle, in which they release and the next state is RUN.
- **Load-use** (RUN, no memwait, no MDU stall).
  - lu = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d).
  - lu gives stall_f = stall_d = 1 and flush_e = 1, for a single cycle.
- **Redirect.** pcsrc_e (no memwait) gives flush_d = flush_e = 1. It overrides lu: stall_f = stall_d = 0 in that cycle.
- **Watchdog.**
  - wait_cnt increments each cycle in MEM_WAIT or MDU_WAIT and clears in RUN.
  - When wait_cnt == TIMEOUT-1, err_timeout sets. It is sticky until rst.
  - The FSM keeps waiting after the error; there is no forced exit. wait_cnt saturates.
- **stall_cycles.** perf_clr has priority and loads 0. Otherwise the counter increments when stall_f = 1 and saturates at all-ones.
- **busy** = (state != RUN).

Decomposition:
- Package pipe_ctrl_pkg holds:
  - typedef enum ctrl_state_e {RUN, MEM_WAIT, MDU_WAIT};
  - constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
- One natural sub-module: fwd_unit, purely combinational, one instance per operand or a dual-port version.

Test Plan:
- **Load-use.** load_e = 1, rd_e = 5, rs1_d = 5 -> one cycle of stall_f = stall_d = flush_e = 1. Next cycle, with load_e = 0, all = 0.
- **Redirect wins over load-use.** pcsrc_e = 1 together with the load-use hazard above -> flush_d = flush_e = 1, stall_f = stall_d = 0.
- **Memory wait.** dmem_req_m = 1 with dmem_ready low for 3 cycles, and pcsrc_e = 1 throughout -> 3 cycles of stall_f/d/e/m = flush_w = 1 with flush_d/e = 0, and busy = 1 from the 2nd cycle. On the 4th cycle, dmem_ready = 1 -> stalls drop and state = RUN.
- **Mul/div wait.** mdu_start_e = 1, mdu_done after 4 cycles -> stall_f/d/e = flush_m = 1 for 4 cycles, release on the done cycle, stall_cycles = 4.
- **Watchdog.** TIMEOUT = 8, mdu_done held low -> err_timeout rises at the 8th wait cycle and stays 1. An async rst mid-wait clears the state and counters immediately, without waiting for clk.
- **Forwarding and perf counter.**
  - regwrite_m = 1, rd_m = 3, regwrite_w = 1, rd_w = 3, rs1_e = 3 -> fwd_a_e = 10.
  - With rd_m = 0 -> fwd_a_e = 01.
  - perf_clr together with a stall cycle -> stall_cycles = 0.
